// File: rtl/acc_mq_seq_alu_if.sv
// Register-bus and handshake bundle for acc_mq_seq_alu.
// The master drives commands and load data; the slave returns outBUS, status and flags.
interface acc_mq_seq_alu_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       INS;
    logic             LDAcc;
    logic             LDMQ;
    logic             LDDR;
    logic             STAcc;
    logic             STMQ;
    logic             STDR;
    logic [WIDTH-1:0] inBUS;
    logic [WIDTH-1:0] outBUS;
    logic             RDY;
    logic             done;
    logic             C;
    logic             Z;

    modport master (
        output start, INS, LDAcc, LDMQ, LDDR, STAcc, STMQ, STDR, inBUS,
        input  outBUS, RDY, done, C, Z
    );

    modport slave (
        input  start, INS, LDAcc, LDMQ, LDDR, STAcc, STMQ, STDR, inBUS,
        output outBUS, RDY, done, C, Z
    );
endinterface

// File: rtl/acc_mq_seq_alu.sv
// Acc/MQ/DR datapath: single-cycle ALU ops plus a WIDTH-step shift-and-add multiply.
// Build option MULT_ACC_EN keeps Acc at MUL start, which turns the multiply into a multiply-accumulate.
module acc_mq_seq_alu #(
    parameter int WIDTH = 8,
    parameter int CNTW  = $clog2(WIDTH + 1)
) (
    input  logic              clock,
    input  logic              rst_n,
    acc_mq_seq_alu_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(WIDTH);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  mq_q, mq_d;
    logic [WIDTH-1:0]  dr_q, dr_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              c_q, c_d;
    logic              z_q, z_d;
    logic              done_q, done_d;

    logic [WIDTH:0]    add_s;
    logic [WIDTH:0]    sub_s;
    logic [WIDTH:0]    mul_sum_s;
    logic [WIDTH-1:0]  alu_res_s;
    logic              alu_c_s;

    // ALU result and carry for the opcode currently on INS
    always_comb begin
        add_s     = {1'b0, acc_q} + {1'b0, dr_q};
        sub_s     = {1'b0, acc_q} - {1'b0, dr_q};
        mul_sum_s = {1'b0, acc_q} + {1'b0, (mq_q[0] ? dr_q : {WIDTH{1'b0}})};
        alu_res_s = acc_q;
        alu_c_s   = c_q;
        case (bus.INS)
            OP_ADD: begin
                alu_res_s = add_s[WIDTH-1:0];
                alu_c_s   = add_s[WIDTH];
            end
            OP_SUB: begin
                // the extra bit of the difference is a borrow, so C is its inverse
                alu_res_s = sub_s[WIDTH-1:0];
                alu_c_s   = ~sub_s[WIDTH];
            end
            OP_AND:  alu_res_s = acc_q & dr_q;
            OP_OR:   alu_res_s = acc_q | dr_q;
            OP_XOR:  alu_res_s = acc_q ^ dr_q;
            OP_NOT:  alu_res_s = ~acc_q;
            default: alu_res_s = acc_q;
        endcase
    end

    // Sequencer next state, register updates and completion pulse
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        dr_d    = dr_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        z_d     = z_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.INS == OP_MUL) begin
                        state_d = ST_MUL;
                        cnt_d   = CNT_FULL;
`ifdef MULT_ACC_EN
                        acc_d   = acc_q;
`else
                        acc_d   = {WIDTH{1'b0}};
`endif
                    end else if (bus.INS != OP_NOP) begin
                        done_d = 1'b1;
                        acc_d  = alu_res_s;
                        c_d    = alu_c_s;
                        z_d    = (alu_res_s == {WIDTH{1'b0}});
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    if (bus.LDAcc) begin
                        acc_d = bus.inBUS;
                    end else begin
                        acc_d = acc_q;
                    end
                    if (bus.LDMQ) begin
                        mq_d = bus.inBUS;
                    end else begin
                        mq_d = mq_q;
                    end
                    if (bus.LDDR) begin
                        dr_d = bus.inBUS;
                    end else begin
                        dr_d = dr_q;
                    end
                end
            end
            ST_MUL: begin
                // {cy,sum,MQ} shifted right by one
                acc_d = mul_sum_s[WIDTH:1];
                mq_d  = {mul_sum_s[0], mq_q[WIDTH-1:1]};
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    c_d     = 1'b0;
                    z_d     = ({acc_d, mq_d} == {(2 * WIDTH){1'b0}});
                end else begin
                    state_d = ST_MUL;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNTW{1'b0}};
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= {WIDTH{1'b0}};
            mq_q    <= {WIDTH{1'b0}};
            dr_q    <= {WIDTH{1'b0}};
            cnt_q   <= {CNTW{1'b0}};
            c_q     <= 1'b0;
            z_q     <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            dr_q    <= dr_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            z_q     <= z_d;
            done_q  <= done_d;
        end
    end

    assign bus.RDY    = (state_q == ST_IDLE);
    assign bus.done   = done_q;
    assign bus.C      = c_q;
    assign bus.Z      = z_q;
    assign bus.outBUS = (acc_q & {WIDTH{bus.STAcc}})
                      | (mq_q  & {WIDTH{bus.STMQ}})
                      | (dr_q  & {WIDTH{bus.STDR}});

endmodule

// File: tb/tb_acc_mq_seq_alu.sv
// Directed bench for acc_mq_seq_alu (WIDTH=8) with a behavioural model compared every cycle.
// Honours MULT_ACC_EN to select the multiply-accumulate expectations.
module tb_acc_mq_seq_alu;
    localparam int W = 8;
`ifdef MULT_ACC_EN
    localparam bit MAC = 1'b1;
`else
    localparam bit MAC = 1'b0;
`endif

    logic clock = 1'b0;
    logic rst_n;
    always #5 clock = ~clock;

    acc_mq_seq_alu_if #(.WIDTH(W)) bus();
    acc_mq_seq_alu #(.WIDTH(W)) dut (.clock(clock), .rst_n(rst_n), .bus(bus));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Behavioural model: whole-operation arithmetic, MUL result appears after W cycles
    logic [W-1:0]   m_acc, m_mq, m_dr;
    logic           m_c, m_z, m_done;
    int             m_cnt;
    logic [2*W-1:0] m_prod;

    function automatic logic [W:0] f_alu(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] d, input logic c);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, d};
            3'd1:    return {(a >= d), 8'(a - d)};
            3'd2:    return {c, a & d};
            3'd3:    return {c, a | d};
            3'd4:    return {c, a ^ d};
            3'd5:    return {c, ~a};
            default: return {c, a};
        endcase
    endfunction

    wire [W:0]     m_alu    = f_alu(bus.INS, m_acc, m_dr, m_c);
    wire [2*W-1:0] m_mulres = 16'(m_mq) * 16'(m_dr) + (MAC ? 16'(m_acc) : 16'h0000);

    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            m_acc <= 8'h00; m_mq <= 8'h00; m_dr <= 8'h00;
            m_c <= 1'b0; m_z <= 1'b1; m_done <= 1'b0; m_cnt <= 0; m_prod <= 16'h0000;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_acc  <= m_prod[2*W-1:W];
                m_mq   <= m_prod[W-1:0];
                m_c    <= 1'b0;
                m_z    <= (m_prod == 16'h0000);
                m_done <= 1'b1;
            end else begin
                m_done <= 1'b0;
            end
        end else begin
            m_done <= 1'b0;
            if (bus.start) begin
                if (bus.INS == 3'b110) begin
                    m_cnt  <= W;
                    m_prod <= m_mulres;
                end else begin
                    m_done <= 1'b1;
                    if (bus.INS != 3'b111) begin
                        m_acc <= m_alu[W-1:0];
                        m_c   <= m_alu[W];
                        m_z   <= (m_alu[W-1:0] == 8'h00);
                    end
                end
            end else begin
                if (bus.LDAcc) m_acc <= bus.inBUS;
                if (bus.LDMQ)  m_mq  <= bus.inBUS;
                if (bus.LDDR)  m_dr  <= bus.inBUS;
            end
        end
    end

    // Every-cycle comparison; register contents only while the model is idle
    always @(negedge clock) begin
        chk("rdy", bus.RDY, (m_cnt == 0));
        chk("done", bus.done, m_done);
        if (m_cnt == 0) begin
            chk("c", bus.C, m_c);
            chk("z", bus.Z, m_z);
            chk("outbus", bus.outBUS, (bus.STAcc ? m_acc : 8'h00) | (bus.STMQ ? m_mq : 8'h00)
                                    | (bus.STDR ? m_dr : 8'h00));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ld(input logic a, input logic m, input logic d, input logic [W-1:0] v);
        bus.LDAcc = a; bus.LDMQ = m; bus.LDDR = d; bus.inBUS = v;
        tick();
        bus.LDAcc = 1'b0; bus.LDMQ = 1'b0; bus.LDDR = 1'b0;
    endtask

    task automatic do_op(input logic [2:0] op);
        bus.start = 1'b1; bus.INS = op;
        tick();
        bus.start = 1'b0; bus.INS = 3'b111;
    endtask

    task automatic rd(input logic [2:0] st, output logic [W-1:0] v);
        {bus.STAcc, bus.STMQ, bus.STDR} = st;
        #1;
        v = bus.outBUS;
        {bus.STAcc, bus.STMQ, bus.STDR} = 3'b100;
    endtask

    task automatic wait_mul(output int n);
        logic seen;
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus.RDY) begin
                seen = 1'b1;
                break;
            end
            n++;
        end
        chk("mul_timeout", seen, 1'b1);
    endtask

    task automatic mul_check(input string nm, input logic [W-1:0] ea, input logic [W-1:0] em,
                             input int elat);
        int n;
        logic [W-1:0] v;
        do_op(3'b110);
        wait_mul(n);
        chk({nm, "_lat"}, n, elat);
        chk({nm, "_done"}, bus.done, 1'b1);
        rd(3'b100, v);
        chk({nm, "_acc"}, v, ea);
        rd(3'b010, v);
        chk({nm, "_mq"}, v, em);
    endtask

    initial begin
        logic [W-1:0] v;
        int n;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.INS = 3'b111; bus.inBUS = 8'h00;
        bus.LDAcc = 1'b0; bus.LDMQ = 1'b0; bus.LDDR = 1'b0;
        bus.STAcc = 1'b1; bus.STMQ = 1'b1; bus.STDR = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_bus", bus.outBUS, 8'h00);
        chk("rst_rdy", bus.RDY, 1'b1);
        chk("rst_z", bus.Z, 1'b1);
        chk("rst_done", bus.done, 1'b0);
        @(posedge clock); #1;
        rst_n = 1'b1;
        bus.STMQ = 1'b0; bus.STDR = 1'b0;

        ld(1'b1, 1'b0, 1'b0, 8'hF0);
        ld(1'b0, 1'b0, 1'b1, 8'h20);
        do_op(3'b000);
        @(negedge clock);
        chk("add_done", bus.done, 1'b1);
        chk("add_acc", bus.outBUS, 8'h10);
        chk("add_c", bus.C, 1'b1);
        chk("add_z", bus.Z, 1'b0);

        ld(1'b0, 1'b0, 1'b1, 8'h10);
        do_op(3'b001);
        @(negedge clock);
        chk("sub_acc", bus.outBUS, 8'h00);
        chk("sub_c", bus.C, 1'b1);
        chk("sub_z", bus.Z, 1'b1);

        ld(1'b1, 1'b0, 1'b0, 8'h03);
        ld(1'b0, 1'b0, 1'b1, 8'h04);
        do_op(3'b001);
        @(negedge clock);
        chk("subb_acc", bus.outBUS, 8'hFF);
        chk("subb_c", bus.C, 1'b0);

        // load colliding with an accepted ADD must lose
        bus.LDAcc = 1'b1; bus.inBUS = 8'h99;
        do_op(3'b000);
        bus.LDAcc = 1'b0;
        @(negedge clock);
        chk("ldadd_acc", bus.outBUS, 8'h03);
        chk("ldadd_c", bus.C, 1'b1);

        do_op(3'b100);
        do_op(3'b101);
        do_op(3'b111);
        @(negedge clock);
        chk("b2b_acc", bus.outBUS, 8'hF8);
        chk("b2b_c", bus.C, 1'b1);
        chk("b2b_z", bus.Z, 1'b0);
        ld(1'b0, 1'b0, 1'b1, 8'h0F);
        do_op(3'b010);
        do_op(3'b011);
        @(negedge clock);
        chk("andor_acc", bus.outBUS, 8'h0F);

        ld(1'b1, 1'b0, 1'b0, 8'h55);
        ld(1'b0, 1'b1, 1'b0, 8'd13);
        ld(1'b0, 1'b0, 1'b1, 8'd11);
        mul_check("mul13x11", 8'h00, MAC ? 8'hE4 : 8'h8F, 8);
        chk("mul_c", bus.C, 1'b0);

        ld(1'b1, 1'b0, 1'b0, 8'h12);
        ld(1'b0, 1'b1, 1'b1, 8'hFF);
        mul_check("mulff", 8'hFE, MAC ? 8'h13 : 8'h01, 8);

        ld(1'b1, 1'b0, 1'b0, 8'h05);
        ld(1'b0, 1'b1, 1'b0, 8'd13);
        ld(1'b0, 1'b0, 1'b1, 8'd11);
        mul_check("mac", 8'h00, MAC ? 8'h94 : 8'h8F, 8);

        // start and LDMQ during MUL are ignored
        ld(1'b1, 1'b0, 1'b0, 8'h00);
        ld(1'b0, 1'b1, 1'b0, 8'd13);
        do_op(3'b110);
        tick();
        bus.start = 1'b1; bus.INS = 3'b000; bus.LDMQ = 1'b1; bus.inBUS = 8'hAA;
        tick();
        bus.start = 1'b0; bus.INS = 3'b111; bus.LDMQ = 1'b0;
        wait_mul(n);
        chk("ign_lat", n, 6);
        rd(3'b100, v);
        chk("ign_acc", v, 8'h00);
        rd(3'b010, v);
        chk("ign_mq", v, 8'h8F);
        @(negedge clock);
        chk("ign_done2", bus.done, 1'b0);

        // reset in the middle of a multiply
        do_op(3'b110);
        repeat (3) tick();
        rst_n = 1'b0;
        bus.STMQ = 1'b1; bus.STDR = 1'b1;
        #1;
        chk("abort_bus", bus.outBUS, 8'h00);
        chk("abort_rdy", bus.RDY, 1'b1);
        chk("abort_done", bus.done, 1'b0);
        tick();
        rst_n = 1'b1;
        bus.STMQ = 1'b0; bus.STDR = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (bus.done) n++;
        end
        chk("abort_nodone", n, 0);
        @(posedge clock); #1;
        ld(1'b0, 1'b1, 1'b0, 8'd13);
        ld(1'b0, 1'b0, 1'b1, 8'd11);
        mul_check("post_abort", 8'h00, 8'h8F, 8);

        repeat (2) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
